// File: rtl/axi_mem_arbiter.sv
// Round-robin arbiter sharing one valid/ready memory port among NUM_REQ requesters.
// One transaction in flight; stalled handshakes are aborted after TIMEOUT cycles.
module axi_mem_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_wr_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_wr_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wr_data,
  output logic [NUM_REQ-1:0]          req_wr_ready,
  input  logic [NUM_REQ-1:0]          req_rd_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_rd_addr,
  output logic [NUM_REQ-1:0]          req_rd_ready,
  output logic [NUM_REQ-1:0]          req_resp_valid,
  output logic [DATA_W-1:0]           req_rd_data,
  output logic                        mem_write_valid,
  output logic [ADDR_W-1:0]           mem_write_addr,
  output logic [DATA_W-1:0]           mem_write_data,
  input  logic                        mem_write_ready,
  output logic                        mem_read_valid,
  output logic [ADDR_W-1:0]           mem_read_addr,
  input  logic                        mem_read_ready,
  input  logic [DATA_W-1:0]           mem_read_data,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        timeout_err,
  input  logic                        err_clr
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WR_XFER, RD_XFER, RD_DATA} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     last_q, last_d;
  logic [ID_W-1:0]     grant_q, grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  resp_q, resp_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                err_q, err_d;
  logic                err_set;
  logic [NUM_REQ-1:0]  pending;
  logic [NUM_REQ-1:0]  wr_ready_c, rd_ready_c;
  logic                found;
  logic [ID_W-1:0]     win;
  int unsigned         idx;
  logic                at_limit;

  logic [ADDR_W-1:0] wr_addr_a [NUM_REQ];
  logic [DATA_W-1:0] wr_data_a [NUM_REQ];
  logic [ADDR_W-1:0] rd_addr_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign wr_addr_a[g] = req_wr_addr[g*ADDR_W +: ADDR_W];
    assign wr_data_a[g] = req_wr_data[g*DATA_W +: DATA_W];
    assign rd_addr_a[g] = req_rd_addr[g*ADDR_W +: ADDR_W];
  end

  assign pending  = req_wr_valid | req_rd_valid;
  assign at_limit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Round-robin pick: first pending requester after the last grantee, with wrap.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last_q) + k) % NUM_REQ;
      if (!found && pending[ID_W'(idx)]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_d    = grant_q;
    addr_d     = addr_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    resp_d     = '0;
    rd_data_d  = rd_data_q;
    err_set    = 1'b0;
    wr_ready_c = '0;
    rd_ready_c = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          last_d  = win;
          grant_d = win;
          cnt_d   = '0;
          if (req_wr_valid[win]) begin
            wr_ready_c[win] = 1'b1;
            addr_d          = wr_addr_a[win];
            data_d          = wr_data_a[win];
            state_d         = WR_XFER;
          end else begin
            rd_ready_c[win] = 1'b1;
            addr_d          = rd_addr_a[win];
            state_d         = RD_XFER;
          end
        end
      end
      WR_XFER: begin
        if (mem_write_ready) begin
          resp_d[last_q] = 1'b1;
          state_d        = IDLE;
        end else if (at_limit) begin
          resp_d[last_q] = 1'b1;
          err_set        = 1'b1;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD_XFER: begin
        if (mem_read_ready) begin
          state_d = RD_DATA;
        end else if (at_limit) begin
          resp_d[last_q] = 1'b1;
          rd_data_d      = DATA_W'(32'hDEADBEEF);
          err_set        = 1'b1;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD_DATA: begin
        rd_data_d      = mem_read_data;
        resp_d[last_q] = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= ID_W'(NUM_REQ - 1);
      grant_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      resp_q    <= '0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      resp_q    <= resp_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
    end
  end

  // Accept strobes are combinational from IDLE and forced low while in reset.
  assign req_wr_ready    = wr_ready_c & ~{NUM_REQ{rst}};
  assign req_rd_ready    = rd_ready_c & ~{NUM_REQ{rst}};
  assign req_resp_valid  = resp_q;
  assign req_rd_data     = rd_data_q;
  assign mem_write_valid = (state_q == WR_XFER);
  assign mem_write_addr  = addr_q;
  assign mem_write_data  = data_q;
  assign mem_read_valid  = (state_q == RD_XFER);
  assign mem_read_addr   = addr_q;
  assign grant_id        = grant_q;
  assign busy            = (state_q != IDLE);
  assign timeout_err     = err_q;

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Scoreboard bench for axi_mem_arbiter: requester agents, a memory model with
// selectable ready behaviour, and a transaction-level reference model.
module tb_axi_mem_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NUM_REQ-1:0]        req_wr_valid, req_wr_ready, req_rd_valid, req_rd_ready, req_resp_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_wr_addr, req_rd_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wr_data;
  logic [DATA_W-1:0]         req_rd_data, mem_write_data, mem_read_data;
  logic [ADDR_W-1:0]         mem_write_addr, mem_read_addr;
  logic                      mem_write_valid, mem_write_ready, mem_read_valid, mem_read_ready;
  logic [1:0]                grant_id;
  logic                      busy, timeout_err;
  logic                      err_clr = 1'b0;

  axi_mem_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_wr_valid(req_wr_valid), .req_wr_addr(req_wr_addr), .req_wr_data(req_wr_data),
    .req_wr_ready(req_wr_ready), .req_rd_valid(req_rd_valid), .req_rd_addr(req_rd_addr),
    .req_rd_ready(req_rd_ready), .req_resp_valid(req_resp_valid), .req_rd_data(req_rd_data),
    .mem_write_valid(mem_write_valid), .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .mem_write_ready(mem_write_ready), .mem_read_valid(mem_read_valid), .mem_read_addr(mem_read_addr),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data), .grant_id(grant_id),
    .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int owner; bit wr; logic [31:0] addr; logic [31:0] data; } txn_t;
  typedef struct { int owner; bit rd; logic [31:0] data; int cyc; } resp_t;

  int    checks = 0;
  int    errors = 0;
  resp_t rq[$];
  int    glog[$];

  // Requester agents
  bit          wr_v [NUM_REQ];
  bit          rd_v [NUM_REQ];
  logic [31:0] wr_a [NUM_REQ];
  logic [31:0] wr_d [NUM_REQ];
  logic [31:0] rd_a [NUM_REQ];
  bit          acc_wr [NUM_REQ];
  bit          acc_rd [NUM_REQ];
  bit          held = 0;
  bit          rnd_on = 0;

  // Memory model: 0 = ready one cycle after valid, 1 = random ready, 2 = never ready
  int          mode = 0;
  logic [31:0] mem [logic [31:0]];
  bit          cont, drive_rd;
  logic [31:0] rd_ret;

  // Reference model state
  bit   act, rd_gap, err_e;
  txn_t cur;
  int   wait_n, last_g, grant_e;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_wr_valid[i]           = wr_v[i];
      req_rd_valid[i]           = rd_v[i];
      req_wr_addr[i*32 +: 32]   = wr_a[i];
      req_wr_data[i*32 +: 32]   = wr_d[i];
      req_rd_addr[i*32 +: 32]   = rd_a[i];
    end
  end

  task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, actual, required, cyc);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hC0DE0000;
  endfunction

  function automatic int pick();
    for (int k = 1; k <= NUM_REQ; k++) begin
      int i;
      i = (last_g + k) % NUM_REQ;
      if (wr_v[i] || rd_v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_init();
    act = 0; rd_gap = 0; err_e = 0; wait_n = 0;
    last_g = NUM_REQ - 1; grant_e = 0;
    cont = 0; drive_rd = 0;
    rq.delete();
    for (int i = 0; i < NUM_REQ; i++) begin acc_wr[i] = 0; acc_rd[i] = 0; end
  endtask

  // Compare DUT against the model for this cycle and predict the coming edge.
  task automatic step();
    bit idle, abort, act_before;
    int w;
    logic [3:0] exp_wr, exp_rd;
    resp_t r;
    idle = !act && !rd_gap;
    act_before = act;
    abort = 0; drive_rd = 0;
    chk("mem_write_valid", mem_write_valid, act && cur.wr);
    chk("mem_read_valid", mem_read_valid, act && !cur.wr);
    if (act && cur.wr) begin
      chk("mem_write_addr", mem_write_addr, cur.addr);
      chk("mem_write_data", mem_write_data, cur.data);
    end
    if (act && !cur.wr) chk("mem_read_addr", mem_read_addr, cur.addr);
    chk("busy", busy, act || rd_gap);
    chk("grant_id", grant_id, grant_e);
    chk("timeout_err", timeout_err, err_e);
    rd_gap = 0;
    if (act) begin
      wait_n++;
      if (cur.wr ? mem_write_ready : mem_read_ready) begin
        if (cur.wr) begin
          mem[cur.addr] = cur.data;
          r = '{cur.owner, 0, 32'h0, cyc + 1};
        end else begin
          rd_ret = rd_mem(cur.addr);
          drive_rd = 1;
          rd_gap = 1;
          r = '{cur.owner, 1, rd_ret, cyc + 2};
        end
        rq.push_back(r);
        act = 0;
      end else if (wait_n == TIMEOUT) begin
        r = '{cur.owner, !cur.wr, 32'hDEADBEEF, cyc + 1};
        rq.push_back(r);
        abort = 1;
        act = 0;
      end
    end
    cont = act_before && act;
    exp_wr = '0; exp_rd = '0;
    w = idle ? pick() : -1;
    if (w >= 0) begin
      if (wr_v[w]) exp_wr[w] = 1'b1; else exp_rd[w] = 1'b1;
      cur = '{w, wr_v[w], wr_v[w] ? wr_a[w] : rd_a[w], wr_d[w]};
      act = 1; wait_n = 0; last_g = w; grant_e = w;
      acc_wr[w] = wr_v[w]; acc_rd[w] = !wr_v[w];
      glog.push_back(w * 2 + int'(wr_v[w]));
    end
    chk("req_wr_ready", req_wr_ready, exp_wr);
    chk("req_rd_ready", req_rd_ready, exp_rd);
    err_e = abort ? 1'b1 : (err_clr ? 1'b0 : err_e);
  endtask

  // Drive memory and agents for the next cycle.
  task automatic apply();
    case (mode)
      0: begin mem_write_ready = cont && cur.wr; mem_read_ready = cont && !cur.wr; end
      1: begin mem_write_ready = ($urandom_range(0, 7) == 0); mem_read_ready = ($urandom_range(0, 7) == 0); end
      default: begin mem_write_ready = 0; mem_read_ready = 0; end
    endcase
    mem_read_data = drive_rd ? rd_ret : $urandom;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc_wr[i]) begin
        wr_v[i] = held;
        if (held) begin wr_a[i] = wr_a[i] + 32'h10; wr_d[i] = $urandom; end
      end
      if (acc_rd[i]) rd_v[i] = 0;
      acc_wr[i] = 0; acc_rd[i] = 0;
      if (rnd_on) begin
        if (!wr_v[i] && $urandom_range(0, 5) == 0) begin
          wr_v[i] = 1; wr_a[i] = 32'($urandom_range(0, 15)) * 4; wr_d[i] = $urandom;
        end
        if (!rd_v[i] && $urandom_range(0, 5) == 0) begin
          rd_v[i] = 1; rd_a[i] = 32'($urandom_range(0, 15)) * 4;
        end
      end
    end
    if (rnd_on) err_clr = ($urandom_range(0, 19) == 0);
  endtask

  task automatic cycle();
    @(negedge clk);
    if (!rst) step();
    @(posedge clk);
    #1;
    apply();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  function automatic bit agents_idle();
    for (int i = 0; i < NUM_REQ; i++) if (wr_v[i] || rd_v[i]) return 0;
    return 1;
  endfunction

  task automatic quiet(input int budget);
    int n;
    n = 0;
    while (!(agents_idle() && !act && !rd_gap && rq.size() == 0) && n < budget) begin
      cycle();
      n++;
    end
    run(2);
    chk("drain_within_budget", (n < budget), 1);
  endtask

  // Assert reset mid-cycle and check outputs clear immediately.
  task automatic do_reset();
    rst = 1;
    #1;
    model_init();
    chk("rst_wr_ready", req_wr_ready, 0);
    chk("rst_rd_ready", req_rd_ready, 0);
    chk("rst_resp_valid", req_resp_valid, 0);
    chk("rst_rd_data", req_rd_data, 0);
    chk("rst_mem_valids", {mem_write_valid, mem_read_valid}, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (!rst && req_resp_valid != '0) begin
      if (rq.size() == 0) begin
        chk("unexpected_resp", req_resp_valid, 0);
      end else begin
        resp_t e;
        e = rq.pop_front();
        chk("resp_owner", req_resp_valid, 64'd1 << e.owner);
        chk("resp_cycle", cyc, e.cyc);
        if (e.rd) chk("resp_rd_data", req_rd_data, e.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      wr_v[i] = 0; rd_v[i] = 0; wr_a[i] = 0; wr_d[i] = 0; rd_a[i] = 0;
    end
    mem_write_ready = 0; mem_read_ready = 0; mem_read_data = 0;
    #2;
    do_reset();

    // Single write from requester 0
    mode = 0;
    wr_v[0] = 1; wr_a[0] = 32'h10; wr_d[0] = 32'hA5A5A5A5;
    quiet(60);
    chk("mem_holds_write", rd_mem(32'h10), 32'hA5A5A5A5);

    // All four write simultaneously and keep requesting
    do_reset();
    glog.delete();
    held = 1;
    for (int i = 0; i < NUM_REQ; i++) begin
      wr_v[i] = 1; wr_a[i] = 32'h100 + 32'(i); wr_d[i] = $urandom;
    end
    for (int n = 0; n < 200 && glog.size() < 5; n++) cycle();
    held = 0;
    quiet(200);
    chk("rr_grant_count", (glog.size() >= 5), 1);
    for (int i = 0; i < 5 && i < glog.size(); i++) chk("rr_grant_order", glog[i] / 2, i % 4);

    // Read from requester 2
    do_reset();
    mem[32'h20] = 32'h00001234;
    rd_v[2] = 1; rd_a[2] = 32'h20;
    quiet(60);

    // Requester 1 with write and read both pending
    do_reset();
    glog.delete();
    wr_v[1] = 1; wr_a[1] = 32'h40; wr_d[1] = 32'h11112222;
    rd_v[1] = 1; rd_a[1] = 32'h44;
    quiet(80);
    chk("wr_rd_count", glog.size(), 2);
    if (glog.size() == 2) begin
      chk("wr_first", glog[0], 3);
      chk("rd_second", glog[1], 2);
    end

    // Stalled memory: write abort, read abort, then clear
    do_reset();
    mode = 2;
    wr_v[0] = 1; wr_a[0] = 32'h80; wr_d[0] = 32'h55AA55AA;
    quiet(60);
    chk("err_after_wr_abort", timeout_err, 1);
    rd_v[0] = 1; rd_a[0] = 32'h84;
    quiet(60);
    err_clr = 1;
    cycle();
    err_clr = 0;
    cycle();
    chk("err_cleared", timeout_err, 0);

    // Reset in the middle of a read, then req3 and req0 contend
    mode = 2;
    rd_v[1] = 1; rd_a[1] = 32'h90;
    run(5);
    wr_v[3] = 1; wr_a[3] = 32'hA0; wr_d[3] = 32'h33333333;
    wr_v[0] = 1; wr_a[0] = 32'hB0; wr_d[0] = 32'h44444444;
    do_reset();
    mode = 0;
    glog.delete();
    quiet(80);
    chk("post_rst_count", glog.size(), 2);
    if (glog.size() == 2) begin
      chk("post_rst_first", glog[0], 1);
      chk("post_rst_second", glog[1], 7);
    end

    // Randomized traffic
    do_reset();
    mode = 1;
    rnd_on = 1;
    run(600);
    rnd_on = 0;
    err_clr = 0;
    mode = 0;
    quiet(3000);
    chk("resp_queue_empty", rq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_mem_arbiter.md
# axi_mem_arbiter

Round-robin arbiter and transaction sequencer that shares the single valid/ready memory port of the AXI-style memory among NUM_REQ requesters. It accepts one write or read per grant, drives the memory handshake, returns read data to the owning requester, and aborts transactions whose ready never arrives (e.g. FIFO full) after a bounded wait. It sits between the requester agents and the memory's `axi_if` port.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, max wait cycles for mem ready before abort (≥2)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_wr_valid  in  NUM_REQ  per-requester write request
- req_wr_addr  in  NUM_REQ*ADDR_W  packed write addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wr_data  in  NUM_REQ*DATA_W  packed write data
- req_wr_ready  out  NUM_REQ  write accepted (one-hot, one cycle)
- req_rd_valid  in  NUM_REQ  per-requester read request
- req_rd_addr  in  NUM_REQ*ADDR_W  packed read addresses
- req_rd_ready  out  NUM_REQ  read accepted (one-hot, one cycle)
- req_resp_valid  out  NUM_REQ  completion pulse to owner (one-hot)
- req_rd_data  out  DATA_W  read data, valid with req_resp_valid
- mem_write_valid / mem_write_addr / mem_write_data  out  1/ADDR_W/DATA_W  memory write channel
- mem_write_ready  in  1
- mem_read_valid / mem_read_addr  out  1/ADDR_W  memory read channel
- mem_read_ready  in  1
- mem_read_data  in  DATA_W  valid the cycle after read handshake
- grant_id  out  $clog2(NUM_REQ)  current/last grantee
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky abort flag
- err_clr  in  1  clears timeout_err

## Operation
- FSM states: IDLE, WR_XFER, RD_XFER, RD_DATA.
- Requester i pending = req_wr_valid[i] | req_rd_valid[i]. In IDLE, winner = first pending requester scanning from (last_grant+1) mod NUM_REQ upward with wrap.
- Winner with write pending: write wins over its own read; req_wr_ready[winner] asserted combinationally in IDLE; at the edge latch addr/data, last_grant<=winner, go WR_XFER. Otherwise read: req_rd_ready[winner], latch addr, go RD_XFER.
- WR_XFER: mem_write_valid=1 with latched addr/data. Handshake = valid & mem_write_ready at an edge -> IDLE, req_resp_valid[owner] pulses next cycle.
- RD_XFER: mem_read_valid=1 with latched addr. Handshake -> RD_DATA.
- RD_DATA: one cycle; at its edge req_rd_data<=mem_read_data, req_resp_valid[owner]<=1 (one cycle), -> IDLE.
- Wait counter cleared on entering an XFER state, +1 per cycle without handshake. Reaching TIMEOUT without handshake: drop valid, set timeout_err, go IDLE; write: resp pulse to owner; read: resp pulse with req_rd_data=32'hDEADBEEF.
- timeout_err: set has priority over err_clr in same cycle.
- Only one outstanding transaction; no request accepted outside IDLE; req_*_ready all 0 when no winner.
- Addresses/data passed unmodified; no range checking (memory owns decode).

## Timing
- Reset (async, immediate): state IDLE, last_grant=NUM_REQ-1 (requester 0 first), all mem_*_valid, req_*_ready, req_resp_valid=0, req_rd_data=0, grant_id=0, busy=0, timeout_err=0, counter 0. Reset mid-transaction drops valids immediately; no completion pulse ever issued for it.
- Write with memory ready registered one cycle after valid: accept edge c0, mem_write_valid c1–c2, handshake edge c2, resp pulse c3, next accept possible c3.
- Read: accept c0, mem_read_valid c1–c2, handshake c2, RD_DATA c3, resp + data c4, next accept c4.
- req_resp_valid and next grant may coincide in the same cycle (different or same requester).
- Abort: valid high exactly TIMEOUT cycles, dropped the cycle after; timeout_err visible same cycle as resp pulse.
- grant_id updates at accept edge, holds until next accept.

## Test plan
- Reset, req0 write addr 0x10 data 0xA5A5A5A5 -> one req_wr_ready[0] pulse, mem_write_* carries 0x10/0xA5A5A5A5, req_resp_valid[0] one pulse, timeout_err=0.
- All 4 requesters write simultaneously, held -> grant order 0,1,2,3,0; grant_id follows; no overlap of mem_write_valid transactions.
- req2 read addr 0x20, memory returns 0x00001234 -> req_resp_valid=4'b0100 one cycle, req_rd_data=0x00001234, at c4.
- req1 wr and rd both valid, others idle -> write accepted first, read on next IDLE; two resp pulses to req1 only.
- mem_write_ready held 0 (FIFO full), TIMEOUT=16 -> valid dropped after 16 cycles, timeout_err=1, resp pulse; repeat as read -> req_rd_data=0xDEADBEEF; err_clr -> timeout_err=0.
- rst pulsed during RD_XFER -> all outputs 0 immediately, no resp pulse; after release req3 and req0 pending -> req0 granted first.
